// File: rtl/rs_mult_issue_sched_pkg.sv
// Shared types and defaults for the MULT issue scheduler: function-unit encoding,
// multiplier geometry defaults and the scheduler state encoding.
package rs_mult_issue_sched_pkg;

    typedef enum logic [1:0] {
        ALU    = 2'd0,
        MULT   = 2'd1,
        LSU    = 2'd2,
        BRANCH = 2'd3
    } func_unit_t;

    localparam int DEF_MULT_LAT  = 4;
    localparam int DEF_OUT_DEPTH = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    function automatic logic is_mult(input func_unit_t f);
        return f == MULT;
    endfunction

endpackage

// File: rtl/rs_mult_issue_sched_pick_sel.sv
// One-hot priority pick: first set candidate at or after 'offset', wrapping to 0.
// An offset of zero gives plain lowest-index priority.
module mult_pick_sel #(
    parameter  int N  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] offset,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   pos;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(offset) + k) % N;
            if (!found && cand[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/rs_mult_issue_sched.sv
// Issue scheduler for the shared pipelined multiplier: picks one ready MULT slot per
// cycle and tracks pipe/result-buffer occupancy. Define MULT_RR_EN for round-robin pick.
module rs_mult_issue_sched
    import rs_mult_issue_sched_pkg::*;
#(
    parameter  int RS_SIZE   = 16,
    parameter  int MULT_LAT  = DEF_MULT_LAT,
    parameter  int OUT_DEPTH = DEF_OUT_DEPTH,
    localparam int IW        = $clog2(RS_SIZE),
    localparam int FW        = $clog2(MULT_LAT + OUT_DEPTH + 1),
    localparam int CW        = $clog2(OUT_DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic       [RS_SIZE-1:0]   req,
    input  func_unit_t [RS_SIZE-1:0]   func_in,
    input  logic                       squash,
    input  logic                       cdb_mult_ack,
    output logic       [RS_SIZE-1:0]   mult_gnt,
    output logic                       mult_issue_valid,
    output logic       [IW-1:0]        mult_issue_idx,
    output logic                       mult_pipe_en,
    output logic                       mult_out_valid,
    output logic       [FW-1:0]        mult_inflight,
    output logic       [1:0]           mult_state
);

    logic [RS_SIZE-1:0]  cand;
    logic [RS_SIZE-1:0]  pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       rr_off;
    logic [MULT_LAT-1:0] stage_q, stage_d;
    logic [CW-1:0]       buf_cnt_q, buf_cnt_d;
    logic [1:0]          state_q, state_d;
    logic [FW-1:0]       inflight_d;
    logic                buf_full, push, pop;

    function automatic logic [FW-1:0] occupancy(input logic [MULT_LAT-1:0] sv,
                                                input logic [CW-1:0]       cnt);
        logic [FW-1:0] sum;
        sum = FW'(cnt);
        for (int i = 0; i < MULT_LAT; i++) sum = sum + FW'(sv[i]);
        return sum;
    endfunction

    always_comb begin
        cand = '0;
        for (int i = 0; i < RS_SIZE; i++) cand[i] = req[i] & is_mult(func_in[i]);
    end

`ifdef MULT_RR_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (mult_issue_valid)
            rr_ptr_d = (pick_idx == IW'(RS_SIZE - 1)) ? '0 : pick_idx + IW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rr_ptr_q <= '0;
        else          rr_ptr_q <= rr_ptr_d;
    end

    assign rr_off = rr_ptr_q;
`else
    assign rr_off = '0;
`endif

    mult_pick_sel #(.N(RS_SIZE)) u_pick (
        .cand   (cand),
        .offset (rr_off),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    // The whole pipe freezes only when the last stage has nowhere to go.
    assign buf_full         = (buf_cnt_q == CW'(OUT_DEPTH));
    assign mult_pipe_en     = ~(stage_q[MULT_LAT-1] & buf_full & ~cdb_mult_ack);
    assign mult_issue_valid = (|cand) & mult_pipe_en & ~squash;
    assign mult_gnt         = mult_issue_valid ? pick_gnt : '0;
    assign mult_issue_idx   = mult_issue_valid ? pick_idx : '0;
    assign mult_out_valid   = (buf_cnt_q != '0);
    assign mult_inflight    = occupancy(stage_q, buf_cnt_q);
    assign mult_state       = state_q;
    assign push             = stage_q[MULT_LAT-1] & mult_pipe_en;
    assign pop              = cdb_mult_ack & mult_out_valid;

    always_comb begin
        stage_d   = stage_q;
        buf_cnt_d = buf_cnt_q;
        if (squash) begin
            stage_d   = '0;
            buf_cnt_d = '0;
        end else begin
            if (mult_pipe_en) stage_d = {stage_q[MULT_LAT-2:0], mult_issue_valid};
            if (push && !pop)      buf_cnt_d = buf_cnt_q + CW'(1);
            else if (pop && !push) buf_cnt_d = buf_cnt_q - CW'(1);
        end
    end

    // State follows next-cycle occupancy: STALL means the pipe freezes unless acked.
    assign inflight_d = occupancy(stage_d, buf_cnt_d);

    always_comb begin
        state_d = ST_BUSY;
        if (squash || inflight_d == '0)
            state_d = ST_IDLE;
        else if (stage_d[MULT_LAT-1] && buf_cnt_d == CW'(OUT_DEPTH))
            state_d = ST_STALL;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_q   <= '0;
            buf_cnt_q <= '0;
            state_q   <= ST_IDLE;
        end else begin
            stage_q   <= stage_d;
            buf_cnt_q <= buf_cnt_d;
            state_q   <= state_d;
        end
    end

endmodule
